// File: rtl/segre_pkg.sv
// Shared types and constants for the segre data-side MMU.
package segre_pkg;

    localparam int unsigned DMMU_ADDR_SIZE     = 32;
    localparam int unsigned DCACHE_LANE_SIZE   = 128;
    localparam int unsigned DCACHE_INDEX_SIZE  = 2;
    localparam int unsigned DCACHE_LANE_BYTES  = DCACHE_LANE_SIZE / 8;
    // Byte-offset bits inside one D-cache lane; forced to zero on lane addresses.
    localparam int unsigned DCACHE_OFFSET_SIZE = $clog2(DCACHE_LANE_BYTES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB_REQ = 3'd1,
        RD_REQ = 3'd2,
        RESP   = 3'd3,
        DONE   = 3'd4
    } dmmu_state_e;

    // Offset width for an arbitrary lane size in bits.
    function automatic int unsigned lane_offset_bits(input int unsigned lane_size);
        return $clog2(lane_size / 8);
    endfunction

endpackage

// File: rtl/segre_wb_buffer.sv
// One-entry writeback buffer: holds an evicted dirty lane until memory accepts it.
// A new writeback is taken whenever the slot is free or is being drained this cycle;
// otherwise it is dropped and the sticky error flag is raised.
module segre_wb_buffer
    import segre_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = DMMU_ADDR_SIZE,
    parameter int unsigned LANE_SIZE = DCACHE_LANE_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_i,
    input  logic [ADDR_SIZE-1:0] wb_addr_i,
    input  logic [LANE_SIZE-1:0] wb_data_i,
    input  logic                 drain_i,
    output logic                 valid_o,
    output logic [ADDR_SIZE-1:0] addr_o,
    output logic [LANE_SIZE-1:0] data_o,
    output logic                 err_o
);

    localparam int unsigned          OFFSET     = lane_offset_bits(LANE_SIZE);
    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = {ADDR_SIZE{1'b1}} << OFFSET;

    logic                 r_valid;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [LANE_SIZE-1:0] r_data;
    logic                 r_err;

    logic w_capture;
    logic w_drop;

    // A draining slot is free again at the same edge, so it may be refilled.
    assign w_capture = wb_i & (~r_valid | drain_i);
    assign w_drop    = wb_i & r_valid & ~drain_i;

    // Slot contents: capture has priority over drain when both happen together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_addr  <= wb_addr_i & ALIGN_MASK;
            r_data  <= wb_data_i;
        end else if (drain_i) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_drop) begin
            r_err <= 1'b1;
        end
    end

    assign valid_o = r_valid;
    assign addr_o  = r_addr;
    assign data_o  = r_data;
    assign err_o   = r_err;

endmodule

// File: rtl/segre_dmmu.sv
// Data-side MMU: serialises D-cache writebacks and miss fills onto one lane-wide
// memory port, returns fill lanes with the replacement index, and owns the
// round-robin replacement counter.
module segre_dmmu
    import segre_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = DMMU_ADDR_SIZE,
    parameter int unsigned LANE_SIZE  = DCACHE_LANE_SIZE,
    parameter int unsigned INDEX_SIZE = DCACHE_INDEX_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  miss_i,
    input  logic [ADDR_SIZE-1:0]  miss_addr_i,
    input  logic                  wb_i,
    input  logic [ADDR_SIZE-1:0]  wb_addr_i,
    input  logic [LANE_SIZE-1:0]  wb_data_i,
    output logic                  data_rdy_o,
    output logic [LANE_SIZE-1:0]  data_o,
    output logic [ADDR_SIZE-1:0]  addr_o,
    output logic [INDEX_SIZE-1:0] lru_index_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_SIZE-1:0]  mem_addr_o,
    output logic [LANE_SIZE-1:0]  mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [LANE_SIZE-1:0]  mem_rdata_i,
    output logic                  err_o
);

    localparam int unsigned          OFFSET     = lane_offset_bits(LANE_SIZE);
    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = {ADDR_SIZE{1'b1}} << OFFSET;

    dmmu_state_e r_state;
    dmmu_state_e w_state_next;

    logic [ADDR_SIZE-1:0]  r_miss_addr;
    logic [LANE_SIZE-1:0]  r_fill_data;
    logic [ADDR_SIZE-1:0]  r_fill_addr;
    logic [INDEX_SIZE-1:0] r_fill_lru;
    logic [INDEX_SIZE-1:0] r_lru_cnt;

    logic                  w_buf_valid;
    logic [ADDR_SIZE-1:0]  w_buf_addr;
    logic [LANE_SIZE-1:0]  w_buf_data;
    logic                  w_drain;
    logic                  w_miss_start;
    logic                  w_fill_done;

    // The buffer empties exactly when memory accepts the write it is presenting.
    assign w_drain      = (r_state == WB_REQ) & mem_ack_i;
    // A buffered writeback always wins over a miss, keeping write-before-read order.
    assign w_miss_start = (r_state == IDLE) & ~w_buf_valid & miss_i;
    assign w_fill_done  = (r_state == RD_REQ) & mem_ack_i;

    segre_wb_buffer #(
        .ADDR_SIZE (ADDR_SIZE),
        .LANE_SIZE (LANE_SIZE)
    ) u_wb_buffer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wb_i      (wb_i),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i),
        .drain_i   (w_drain),
        .valid_o   (w_buf_valid),
        .addr_o    (w_buf_addr),
        .data_o    (w_buf_data),
        .err_o     (err_o)
    );

    // Next-state logic for the request sequencer.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_buf_valid) begin
                    w_state_next = WB_REQ;
                end else if (miss_i) begin
                    w_state_next = RD_REQ;
                end
            end
            WB_REQ: begin
                if (mem_ack_i) begin
                    w_state_next = IDLE;
                end
            end
            RD_REQ: begin
                if (mem_ack_i) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = DONE;
            end
            // One dead cycle so a miss still held high is not issued twice.
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch the lane-aligned miss address when a read is started.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_miss_addr <= '0;
        end else if (w_miss_start) begin
            r_miss_addr <= miss_addr_i & ALIGN_MASK;
        end
    end

    // Fill output registers: loaded on read completion, held until the next fill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fill_data <= '0;
            r_fill_addr <= '0;
            r_fill_lru  <= '0;
        end else if (w_fill_done) begin
            r_fill_data <= mem_rdata_i;
            r_fill_addr <= r_miss_addr;
            r_fill_lru  <= r_lru_cnt;
        end
    end

    // Round-robin replacement counter, advanced once per delivered fill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lru_cnt <= '0;
        end else if (r_state == RESP) begin
            r_lru_cnt <= r_lru_cnt + 1'b1;
        end
    end

    // Memory port drive: only the two request states present a transaction.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (r_state)
            WB_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = w_buf_addr;
                mem_wdata_o = w_buf_data;
            end
            RD_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = r_miss_addr;
            end
            default: begin
            end
        endcase
    end

    assign data_rdy_o  = (r_state == RESP);
    assign data_o      = r_fill_data;
    assign addr_o      = r_fill_addr;
    assign lru_index_o = r_fill_lru;

endmodule
